// File: rtl/riscv_pkg.sv
// Shared RV32I constants and issue-queue types.
// Imported by the instruction issue path and its FIFO.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] I_TYPE_OP = 7'b0010011;
    localparam logic [6:0] R_TYPE_OP = 7'b0110011;

    localparam logic [2:0] F3_ADD     = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [XLEN-1:0] BUBBLE_INSTR = 32'h0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } issue_state_e;

    function automatic logic [6:0] opcode_of(input logic [XLEN-1:0] instr);
        return instr[6:0];
    endfunction

    function automatic logic [2:0] funct3_of(input logic [XLEN-1:0] instr);
        return instr[14:12];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy flags and sticky overflow.
// The head word is visible combinationally on rd_data.
module sync_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = XLEN,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             ovf
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;
    logic             push;
    logic             pop;

    // Acceptance uses the registered flags only, so a pop never frees a slot
    // for a write in the same cycle.
    assign push = wr_en & ~full_q;
    assign pop  = rd_en & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (wr_en & full_q);
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == (AW+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;
    assign ovf     = ovf_q;

endmodule

// File: rtl/instr_issue_queue.sv
// Buffers loader-written RV32I words and paces them onto the CPU
// instruction port: HOLD_CYCLES valid, then GAP_CYCLES of bubble.
module instr_issue_queue
    import riscv_pkg::*;
#(
    parameter  int DEPTH       = 8,
    parameter  int HOLD_CYCLES = 5,
    parameter  int GAP_CYCLES  = 1,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic            cpu_clk,
    input  logic            cpu_rst,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_data,
    output logic            full,
    output logic            empty,
    output logic [AW:0]     count,
    output logic            ovf,
    output logic [XLEN-1:0] cpu_instruction,
    output logic            cpu_instruction_RDY_BSY,
    output logic            issue_pulse
);

    localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

    issue_state_e    state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            rdy_q, rdy_d;
    logic            pulse_q, pulse_d;
    logic            launch;
    logic [XLEN-1:0] head;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) u_fifo (
        .clk     (cpu_clk),
        .rst     (cpu_rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (launch),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .ovf     (ovf)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        rdy_d   = rdy_q;
        pulse_d = 1'b0;
        launch  = 1'b0;

        unique case (state_q)
            IDLE: begin
                instr_d = BUBBLE_INSTR;
                rdy_d   = 1'b0;
                launch  = ~empty;
            end
            ISSUE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (GAP_CYCLES > 0) begin
                    instr_d = BUBBLE_INSTR;
                    rdy_d   = 1'b0;
                    cnt_d   = GAP_LD;
                    state_d = GAP;
                end else if (!empty) begin
                    launch = 1'b1;
                end else begin
                    instr_d = BUBBLE_INSTR;
                    rdy_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!empty) begin
                    launch = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                instr_d = BUBBLE_INSTR;
                rdy_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Every pop funnels through here so all paths load the same way.
        if (launch) begin
            instr_d = head;
            rdy_d   = 1'b1;
            pulse_d = 1'b1;
            cnt_d   = HOLD_LD;
            state_d = ISSUE;
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            instr_q <= BUBBLE_INSTR;
            rdy_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            rdy_q   <= rdy_d;
            pulse_q <= pulse_d;
        end
    end

    assign cpu_instruction         = instr_q;
    assign cpu_instruction_RDY_BSY = rdy_q;
    assign issue_pulse             = pulse_q;

endmodule

// File: tb/tb_instr_issue_queue.sv
// Scoreboard bench for instr_issue_queue across three pacing configs.
// Stimulus pushes expected (word, cycle) pairs; monitors pop on issue_pulse.
module tb_instr_issue_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wr_data;
    logic        wr_en_a, wr_en_b, wr_en_c;

    logic        full_a, empty_a, ovf_a, rdy_a, pulse_a;
    logic        full_b, empty_b, ovf_b, rdy_b, pulse_b;
    logic        full_c, empty_c, ovf_c, rdy_c, pulse_c;
    logic [3:0]  count_a, count_b, count_c;
    logic [31:0] instr_a, instr_b, instr_c;

    typedef struct {
        logic [31:0] w;
        int          c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int cyc = 0;
    int total_cnt = 0;
    int pass_cnt = 0;
    int hl0 = 0, hl1 = 0, hl2 = 0;
    logic [31:0] cur0 = '0, cur1 = '0, cur2 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_issue_queue #(.DEPTH(8), .HOLD_CYCLES(5), .GAP_CYCLES(1)) u_a (
        .cpu_clk(clk), .cpu_rst(rst), .wr_en(wr_en_a), .wr_data(wr_data),
        .full(full_a), .empty(empty_a), .count(count_a), .ovf(ovf_a),
        .cpu_instruction(instr_a), .cpu_instruction_RDY_BSY(rdy_a),
        .issue_pulse(pulse_a)
    );

    instr_issue_queue #(.DEPTH(8), .HOLD_CYCLES(1), .GAP_CYCLES(0)) u_b (
        .cpu_clk(clk), .cpu_rst(rst), .wr_en(wr_en_b), .wr_data(wr_data),
        .full(full_b), .empty(empty_b), .count(count_b), .ovf(ovf_b),
        .cpu_instruction(instr_b), .cpu_instruction_RDY_BSY(rdy_b),
        .issue_pulse(pulse_b)
    );

    instr_issue_queue #(.DEPTH(8), .HOLD_CYCLES(20), .GAP_CYCLES(0)) u_c (
        .cpu_clk(clk), .cpu_rst(rst), .wr_en(wr_en_c), .wr_data(wr_data),
        .full(full_c), .empty(empty_c), .count(count_c), .ovf(ovf_c),
        .cpu_instruction(instr_c), .cpu_instruction_RDY_BSY(rdy_c),
        .issue_pulse(pulse_c)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s at cycle %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic mon(input int i, input logic p, input logic r,
                       input logic [31:0] ins, input int hold,
                       inout int hl, inout logic [31:0] cur);
        exp_t e;
        bit   have;
        have = 0;
        if (p) begin
            case (i)
                0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
                1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
                default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1; end
            endcase
            if (!have) begin
                chk($sformatf("unexpected_issue_%0d", i), ins, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk($sformatf("issue_word_%0d", i), ins, e.w);
                chk($sformatf("issue_cycle_%0d", i), cyc, e.c);
                cur = e.w;
                hl  = hold;
            end
        end
        chk($sformatf("rdy_%0d", i), r, (hl > 0));
        if (hl > 0) begin
            chk($sformatf("held_word_%0d", i), ins, cur);
            hl--;
        end else begin
            chk($sformatf("bubble_word_%0d", i), ins, 0);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rst) begin
            hl0 = 0;
            hl1 = 0;
            hl2 = 0;
        end else begin
            mon(0, pulse_a, rdy_a, instr_a, 5, hl0, cur0);
            mon(1, pulse_b, rdy_b, instr_b, 1, hl1, cur1);
            mon(2, pulse_c, rdy_c, instr_c, 20, hl2, cur2);
        end
    end

    task automatic put(input int i, input logic [31:0] d, output int k);
        @(negedge clk);
        wr_data = d;
        wr_en_a = (i == 0);
        wr_en_b = (i == 1);
        wr_en_c = (i == 2);
        k = cyc + 1;
    endtask

    task automatic stop();
        @(negedge clk);
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
        wr_en_c = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, kk;
        rst = 1'b1;
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
        wr_en_c = 1'b0;
        wr_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_count", count_a, 0);
        chk("rst_empty", empty_a, 1);
        chk("rst_full", full_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_instr", instr_a, 0);
        chk("rst_rdy", rdy_a, 0);
        chk("rst_pulse", pulse_a, 0);
        repeat (2) @(negedge clk);

        // single addi: valid k+1..k+5, bubble at k+6
        put(0, 32'h00500093, k);
        q0.push_back('{32'h00500093, k + 1});
        stop();
        repeat (10) @(negedge clk);
        chk("single_idle_empty", empty_a, 1);

        // three back-to-back words, period 6
        put(0, 32'h00500093, k);
        q0.push_back('{32'h00500093, k + 1});
        put(0, 32'h00508113, kk);
        q0.push_back('{32'h00508113, k + 7});
        put(0, 32'h002001B3, kk);
        q0.push_back('{32'h002001B3, k + 13});
        stop();
        repeat (22) @(negedge clk);

        // write landing on counter==0 goes through GAP then ISSUE
        put(0, 32'h0000A033, k);
        q0.push_back('{32'h0000A033, k + 1});
        stop();
        wait_cyc(k + 4);
        put(0, 32'h40208133, kk);
        q0.push_back('{32'h40208133, k + 7});
        stop();
        chk("edge_write_not_popped", count_a, 1);
        repeat (10) @(negedge clk);

        // HOLD=1/GAP=0: contiguous, then registered-empty bubble
        put(1, 32'h00100093, k);
        q1.push_back('{32'h00100093, k + 1});
        put(1, 32'h00200113, kk);
        q1.push_back('{32'h00200113, k + 2});
        put(1, 32'h00300193, kk);
        q1.push_back('{32'h00300193, k + 3});
        stop();
        put(1, 32'h00400213, kk);
        q1.push_back('{32'h00400213, k + 5});
        stop();
        chk("b_edge_write_count", count_b, 1);
        repeat (8) @(negedge clk);

        // fill to full, overflow, and rejected write on a pop edge
        for (int i = 0; i < 10; i++) begin
            put(2, 32'h1000_0000 + i, kk);
            if (i == 0) k = kk;
            if (i == 0) q2.push_back('{32'h1000_0000, k + 1});
            else if (i < 9) q2.push_back('{32'h1000_0000 + i, k + 1 + 20 * i});
            if (i == 9) begin
                chk("c_full", full_c, 1);
                chk("c_count8", count_c, 8);
                chk("c_ovf_before", ovf_c, 0);
            end
        end
        stop();
        chk("c_ovf_set", ovf_c, 1);
        chk("c_count_after_drop", count_c, 8);
        wait_cyc(k + 19);
        put(2, 32'hDEAD_0001, kk);
        stop();
        chk("c_pop_edge_reject", count_c, 7);
        chk("c_ovf_sticky", ovf_c, 1);
        wait_cyc(k + 190);
        chk("c_drained", empty_c, 1);

        // reset mid-ISSUE with 3 entries queued
        put(0, 32'h00500093, k);
        q0.push_back('{32'h00500093, k + 1});
        put(0, 32'h00508113, kk);
        put(0, 32'h002001B3, kk);
        put(0, 32'h0000A033, kk);
        stop();
        chk("pre_rst_count", count_a, 3);
        chk("pre_rst_rdy", rdy_a, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_instr", instr_a, 0);
        chk("async_rst_rdy", rdy_a, 0);
        chk("async_rst_count", count_a, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("post_rst_count", count_a, 0);
        chk("post_rst_empty", empty_a, 1);
        repeat (15) @(negedge clk);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
